// File: rtl/pwm_reg_bank_gen.sv
// Register bank with shadowed period/duty and NUM_CH edge-aligned PWM outputs.
// Optional PWM_POLARITY_EN adds the POL register at 0x03 for output inversion.
module pwm_reg_bank_gen #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        reg_addr_i,
  input  logic [WIDTH-1:0]  reg_wdata_i,
  input  logic              reg_write_i,
  output logic [WIDTH-1:0]  reg_rdata_o,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              period_end_o
);

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_PRESC  = 8'h01;
  localparam logic [7:0] A_PERIOD = 8'h02;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_CNT    = 8'h05;

  logic              en;
  logic              pend;
  logic [WIDTH-1:0]  presc;
  logic [WIDTH-1:0]  period;
  logic [WIDTH-1:0]  period_sh;
  logic [WIDTH-1:0]  psh_nxt;
  logic [WIDTH-1:0]  pcnt;
  logic [WIDTH-1:0]  cnt;
  logic [WIDTH-1:0]  cnt_nxt;
  logic [WIDTH-1:0]  duty    [NUM_CH];
  logic [WIDTH-1:0]  duty_sh [NUM_CH];
  logic [WIDTH-1:0]  dsh_nxt [NUM_CH];
  logic [NUM_CH-1:0] pol;
  logic [NUM_CH-1:0] pwm_nxt;
  logic [WIDTH-1:0]  rd_nxt;
  logic              tick;
  logic              bnd;
  logic              do_load;
  logic              wr_ctrl;

  assign wr_ctrl = reg_write_i && (reg_addr_i == A_CTRL);

`ifdef PWM_POLARITY_EN
  localparam logic [7:0] A_POL = 8'h03;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pol <= '0;
    end else if (reg_write_i && reg_addr_i == A_POL) begin
      pol <= NUM_CH'(reg_wdata_i);
    end
  end
`else
  assign pol = '0;
`endif

  always_comb begin
    tick    = en && (pcnt == presc);
    bnd     = tick && (cnt == period_sh);
    do_load = bnd && pend;
    cnt_nxt = cnt;
    if (!en || bnd) begin
      cnt_nxt = '0;
    end else if (tick) begin
      cnt_nxt = cnt + 1'b1;
    end
    psh_nxt = (!en || do_load) ? period : period_sh;
    pwm_nxt = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      dsh_nxt[n] = (!en || do_load) ? duty[n] : duty_sh[n];
      pwm_nxt[n] = (en && (cnt_nxt < dsh_nxt[n])) ^ pol[n];
    end
  end

  always_comb begin
    rd_nxt = '0;
    unique case (1'b1)
      (reg_addr_i == A_CTRL):   rd_nxt = WIDTH'({pend, en});
      (reg_addr_i == A_PRESC):  rd_nxt = presc;
      (reg_addr_i == A_PERIOD): rd_nxt = period;
`ifdef PWM_POLARITY_EN
      (reg_addr_i == A_POL):    rd_nxt = WIDTH'(pol);
`endif
      (reg_addr_i == A_STATUS): rd_nxt = WIDTH'({en, pend});
      (reg_addr_i == A_CNT):    rd_nxt = cnt;
      default: begin
        for (int n = 0; n < NUM_CH; n++) begin
          if (reg_addr_i == 8'(16 + n)) rd_nxt = duty[n];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en           <= 1'b0;
      pend         <= 1'b0;
      presc        <= '0;
      period       <= '1;
      period_sh    <= '1;
      pcnt         <= '0;
      cnt          <= '0;
      pwm_o        <= '0;
      period_end_o <= 1'b0;
      reg_rdata_o  <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        duty[n]    <= '0;
        duty_sh[n] <= '0;
      end
    end else begin
      pcnt         <= (!en || tick) ? '0 : pcnt + 1'b1;
      cnt          <= cnt_nxt;
      period_sh    <= psh_nxt;
      pwm_o        <= pwm_nxt;
      period_end_o <= bnd;
      reg_rdata_o  <= rd_nxt;
      for (int n = 0; n < NUM_CH; n++) begin
        duty_sh[n] <= dsh_nxt[n];
      end
      // a LOAD written on a boundary cycle survives to the next boundary
      if (!en || do_load) pend <= 1'b0;
      if (wr_ctrl) begin
        en <= reg_wdata_i[0];
        if (reg_wdata_i[1]) pend <= 1'b1;
      end
      if (reg_write_i && reg_addr_i == A_PRESC)  presc  <= reg_wdata_i;
      if (reg_write_i && reg_addr_i == A_PERIOD) period <= reg_wdata_i;
      for (int n = 0; n < NUM_CH; n++) begin
        if (reg_write_i && reg_addr_i == 8'(16 + n)) duty[n] <= reg_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_pwm_reg_bank_gen.sv
// Bench for pwm_reg_bank_gen: directed plan steps plus random register traffic
// checked every cycle against an arithmetic reference model.
module tb_pwm_reg_bank_gen;

  localparam int W = 16;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   addr;
  logic [W-1:0] wdata;
  logic         wr;
  logic [W-1:0] rdata;
  logic [N-1:0] pwm;
  logic         pe;

  int total = 0;
  int bad   = 0;

  pwm_reg_bank_gen #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_addr_i   (addr),
    .reg_wdata_i  (wdata),
    .reg_write_i  (wr),
    .reg_rdata_o  (rdata),
    .pwm_o        (pwm),
    .period_end_o (pe)
  );

  always #5 clk = ~clk;

  // reference model state
  int       m_en, m_pend, m_presc, m_period, m_pol;
  int       m_age, m_cnt, m_psh;
  int       m_duty [N];
  int       m_dsh  [N];
  logic [N-1:0] m_pwm;
  logic     m_pe;
  int       m_rd;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_presc = 0; m_period = 'hFFFF; m_pol = 0;
    m_age = 0; m_cnt = 0; m_psh = 'hFFFF;
    for (int n = 0; n < N; n++) begin
      m_duty[n] = 0;
      m_dsh[n]  = 0;
    end
    m_pwm = '0; m_pe = 0; m_rd = 0;
  endtask

  function automatic int model_read(input int a);
    int r;
    r = 0;
    if (a == 0) r = m_pend * 2 + m_en;
    else if (a == 1) r = m_presc;
    else if (a == 2) r = m_period;
`ifdef PWM_POLARITY_EN
    else if (a == 3) r = m_pol;
`endif
    else if (a == 4) r = m_en * 2 + m_pend;
    else if (a == 5) r = m_cnt;
    else if (a >= 16 && a < 16 + N) r = m_duty[a - 16];
    return r;
  endfunction

  // one clock edge of the specified behaviour
  task automatic model_step(input int a, input int d, input bit w);
    int  rd;
    bit  tick, bnd;
    rd  = model_read(a);
    bnd = 0;
    if (m_en != 0) begin
      m_age++;
      tick = (m_age % (m_presc + 1)) == 0;
      bnd  = tick && (m_cnt == m_psh);
      if (bnd) m_cnt = 0;
      else if (tick) m_cnt = m_cnt + 1;
      if (bnd && m_pend != 0) begin
        m_psh = m_period;
        for (int n = 0; n < N; n++) m_dsh[n] = m_duty[n];
        m_pend = 0;
      end
    end else begin
      m_age = 0;
      m_cnt = 0;
      m_pend = 0;
      m_psh = m_period;
      for (int n = 0; n < N; n++) m_dsh[n] = m_duty[n];
    end
    m_pe = bnd;
    for (int n = 0; n < N; n++) begin
      m_pwm[n] = ((m_en != 0) && (m_cnt < m_dsh[n])) ^ (((m_pol >> n) & 1) != 0);
    end
    if (w) begin
      if (a == 0) begin
        m_en = d & 1;
        if ((d & 2) != 0) m_pend = 1;
      end else if (a == 1) m_presc = d & 'hFFFF;
      else if (a == 2) m_period = d & 'hFFFF;
`ifdef PWM_POLARITY_EN
      else if (a == 3) m_pol = d & ((1 << N) - 1);
`endif
      else if (a >= 16 && a < 16 + N) m_duty[a - 16] = d & 'hFFFF;
    end
    m_rd = rd;
  endtask

  task automatic cyc(input int a, input int d, input bit w);
    addr  = 8'(a);
    wdata = W'(d);
    wr    = w;
    @(posedge clk);
    model_step(a, d & 'hFFFF, w);
    #1;
    chk("pwm", 32'(pwm), 32'(m_pwm));
    chk("period_end", 32'(pe), 32'(m_pe));
    chk("rdata", 32'(rdata), 32'(m_rd));
    wr = 1'b0;
  endtask

  task automatic idle(input int k, input int a);
    for (int i = 0; i < k; i++) cyc(a, 0, 0);
  endtask

  task automatic count_hi(input int k, input int ch, output int hi,
                          output int pes);
    hi = 0; pes = 0;
    for (int i = 0; i < k; i++) begin
      cyc(4, 0, 0);
      if (pwm[ch]) hi++;
      if (pe) pes++;
    end
  endtask

  // advance until the next edge is a period boundary (bounded)
  task automatic to_boundary();
    int lim;
    lim = 0;
    while (!((m_age + 1) % (m_presc + 1) == 0 && m_cnt == m_psh)
           && lim < 200) begin
      cyc(4, 0, 0);
      lim++;
    end
    chk("boundary_wait", 32'(lim < 200), 32'd1);
  endtask

  int hi, pes, r, a, d;

  initial begin
    model_reset();
    rst_n = 1'b0;
    addr = '0; wdata = '0; wr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_pe", 32'(pe), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    cyc(2, 0, 0);
    chk("rst_period", 32'(rdata), 32'hFFFF);
    cyc(0, 0, 0);
    chk("rst_ctrl", 32'(rdata), 32'd0);

    // 10-clk period, duty 3
    cyc(1, 0, 1); cyc(2, 9, 1); cyc(16, 3, 1); cyc(0, 1, 1);
    idle(25, 5);
    count_hi(10, 0, hi, pes);
    chk("t2_hi", 32'(hi), 32'd3);
    chk("t2_pe", 32'(pes), 32'd1);

    // duty change without LOAD is not applied
    cyc(16, 7, 1);
    idle(12, 4);
    count_hi(10, 0, hi, pes);
    chk("t3_nolod", 32'(hi), 32'd3);
    cyc(0, 3, 1);
    cyc(4, 0, 0);
    chk("t3_pend", 32'(rdata[0]), 32'd1);
    idle(12, 4);
    chk("t3_clr", 32'(rdata[0]), 32'd0);
    count_hi(10, 0, hi, pes);
    chk("t3_hi", 32'(hi), 32'd7);

    // prescaled period of 15 clk, duty above period
    cyc(0, 0, 1); cyc(1, 2, 1); cyc(2, 4, 1); cyc(17, 5, 1); cyc(0, 1, 1);
    idle(20, 5);
    count_hi(15, 1, hi, pes);
    chk("t4_hi", 32'(hi), 32'd15);
    chk("t4_pe", 32'(pes), 32'd1);

    // LOAD on the boundary edge is deferred one period
    cyc(17, 2, 1);
    to_boundary();
    cyc(0, 3, 1);
    chk("t5_pe", 32'(pe), 32'd1);
    count_hi(15, 1, hi, pes);
    chk("t5_old", 32'(hi), 32'd15);
    count_hi(15, 1, hi, pes);
    chk("t5_new", 32'(hi), 32'd6);
    idle(4, 5);
    cyc(0, 0, 1);
    cyc(5, 0, 0);
    cyc(5, 0, 0);
    chk("t5_cnt", 32'(rdata), 32'd0);
    chk("t5_pwm", 32'(pwm), 32'd0);

`ifdef PWM_POLARITY_EN
    cyc(3, 1, 1);
    cyc(4, 0, 0);
    chk("pol_idle", 32'(pwm[0]), 32'd1);
    cyc(1, 0, 1); cyc(2, 9, 1); cyc(16, 3, 1); cyc(0, 1, 1);
    idle(25, 4);
    count_hi(10, 0, hi, pes);
    chk("pol_hi", 32'(hi), 32'd7);
    cyc(0, 0, 1);
`else
    cyc(3, 'hFFFF, 1);
    cyc(3, 0, 0);
    chk("pol_unmapped", 32'(rdata), 32'd0);
`endif

    // random register traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) begin
        cyc(0, $urandom, 1);
      end else if (r < 14) begin
        cyc(2, $urandom_range(0, 12), 1);
      end else if (r < 22) begin
        cyc(16 + $urandom_range(0, N - 1), $urandom_range(0, 14), 1);
      end else if (r < 25 && m_en == 0) begin
        cyc(1, $urandom_range(0, 3), 1);
      end else if (r < 28) begin
        a = $urandom_range(0, 4);
        d = $urandom;
        case (a)
          0: cyc(3, d, 1);
          1: cyc(4, d, 1);
          2: cyc(5, d, 1);
          3: cyc(16 + N, d, 1);
          default: cyc(8'hFF, d, 1);
        endcase
      end else begin
        a = $urandom_range(0, 8);
        cyc(a < 6 ? a : 16 + $urandom_range(0, N), 0, 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
